// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares a single-port data memory (sync write, combinational read) between
// port A (core load/store) and port B (DMA/debug) with round-robin arbitration and optional
// locked bursts of up to MAX_BURST beats.
// Ports:
//   CLK, RESET            clock (rising edge), asynchronous active-low reset
//   X_REQ/WE/LOCK/ADDR/WDATA  per-port request (X = A or B), held until granted
//   X_GNT                 combinational grant; transfer completes at the next CLK edge
//   X_RVALID/X_ERR        one-cycle response pulses; X_RDATA holds the last read result
//   MEM_*                 connection to the memory
module data_mem_arbiter #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             A_REQ,
  input  logic             A_WE,
  input  logic             A_LOCK,
  input  logic [WIDTH-1:0] A_ADDR,
  input  logic [WIDTH-1:0] A_WDATA,
  input  logic             B_REQ,
  input  logic             B_WE,
  input  logic             B_LOCK,
  input  logic [WIDTH-1:0] B_ADDR,
  input  logic [WIDTH-1:0] B_WDATA,
  output logic             A_GNT,
  output logic             A_RVALID,
  output logic [WIDTH-1:0] A_RDATA,
  output logic             A_ERR,
  output logic             B_GNT,
  output logic             B_RVALID,
  output logic [WIDTH-1:0] B_RDATA,
  output logic             B_ERR,
  output logic [WIDTH-1:0] MEM_ADDRESS,
  output logic             MEM_WRITE_READ,
  output logic [WIDTH-1:0] MEM_WRITE_DATA,
  input  logic [WIDTH-1:0] MEM_READ_DATA
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] OWN_A = 2'd1;
  localparam logic [1:0] OWN_B = 2'd2;

  localparam int unsigned BW       = $clog2(MAX_BURST + 1);
  localparam bit          BURST_EN = (MAX_BURST > 1);

  logic [1:0]       state_q, state_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic             last_q, last_d;  // 1 = B was granted last
  logic             a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic             a_err_q, a_err_d, b_err_q, b_err_d;
  logic [WIDTH-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

  logic             gnt_a, gnt_b, any_gnt, oor;
  logic             sel_we, sel_lock;
  logic [WIDTH-1:0] sel_addr, sel_wdata;
  logic [BW-1:0]    beat_inc;

  // Grant selection. Grants are masked by RESET so they drop as soon as reset asserts.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    case (state_q)
      IDLE: begin
        if (A_REQ && B_REQ) begin
          gnt_a = last_q;
          gnt_b = ~last_q;
        end else begin
          gnt_a = A_REQ;
          gnt_b = B_REQ;
        end
      end
      OWN_A:   gnt_a = A_REQ;
      OWN_B:   gnt_b = B_REQ;
      default: ;
    endcase
    A_GNT   = gnt_a & RESET;
    B_GNT   = gnt_b & RESET;
    any_gnt = A_GNT | B_GNT;
  end

  // Memory-side mux; out-of-range accesses are granted but never write.
  always_comb begin
    sel_we    = B_GNT ? B_WE    : A_WE;
    sel_lock  = B_GNT ? B_LOCK  : A_LOCK;
    sel_addr  = B_GNT ? B_ADDR  : A_ADDR;
    sel_wdata = B_GNT ? B_WDATA : A_WDATA;
    oor       = sel_addr >= WIDTH'(MEM_DEPTH);

    MEM_ADDRESS    = any_gnt ? sel_addr : '0;
    MEM_WRITE_DATA = any_gnt ? sel_wdata : '0;
    MEM_WRITE_READ = any_gnt & sel_we & ~oor;
  end

  // Ownership FSM and burst beat counter.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    last_d   = last_q;
    beat_inc = beat_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (any_gnt) begin
          last_d = B_GNT;
          if (sel_lock && BURST_EN) begin
            state_d = B_GNT ? OWN_B : OWN_A;
            beat_d  = BW'(1);
          end
        end
      end
      OWN_A, OWN_B: begin
        if (any_gnt) begin
          beat_d = beat_inc;
          if (!sel_lock || (beat_inc == BW'(MAX_BURST))) begin
            state_d = IDLE;
            beat_d  = '0;
          end
        end else begin
          // Owner dropped its request: release ownership right away.
          state_d = IDLE;
          beat_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // Responses: reads and any out-of-range access produce RVALID one cycle after the grant.
  always_comb begin
    a_rvalid_d = A_GNT & (~sel_we | oor);
    b_rvalid_d = B_GNT & (~sel_we | oor);
    a_err_d    = A_GNT & oor;
    b_err_d    = B_GNT & oor;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    if (a_rvalid_d) a_rdata_d = oor ? '0 : MEM_READ_DATA;
    if (b_rvalid_d) b_rdata_d = oor ? '0 : MEM_READ_DATA;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      last_q     <= 1'b1;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_err_q    <= 1'b0;
      b_err_q    <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      last_q     <= last_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_err_q    <= a_err_d;
      b_err_q    <= b_err_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  assign A_RVALID = a_rvalid_q;
  assign B_RVALID = b_rvalid_q;
  assign A_ERR    = a_err_q;
  assign B_ERR    = b_err_q;
  assign A_RDATA  = a_rdata_q;
  assign B_RDATA  = b_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed bench for data_mem_arbiter with a simple 256-word memory model.
module tb_data_mem_arbiter;

  localparam int unsigned WIDTH = 32;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             A_REQ, A_WE, A_LOCK, B_REQ, B_WE, B_LOCK;
  logic [WIDTH-1:0] A_ADDR, A_WDATA, B_ADDR, B_WDATA;
  logic             A_GNT, A_RVALID, A_ERR, B_GNT, B_RVALID, B_ERR;
  logic [WIDTH-1:0] A_RDATA, B_RDATA;
  logic [WIDTH-1:0] MEM_ADDRESS, MEM_WRITE_DATA, MEM_READ_DATA;
  logic             MEM_WRITE_READ;

  logic [WIDTH-1:0] mem [256];
  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  data_mem_arbiter #(.WIDTH(32), .MEM_DEPTH(256), .MAX_BURST(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .A_REQ(A_REQ), .A_WE(A_WE), .A_LOCK(A_LOCK), .A_ADDR(A_ADDR), .A_WDATA(A_WDATA),
    .B_REQ(B_REQ), .B_WE(B_WE), .B_LOCK(B_LOCK), .B_ADDR(B_ADDR), .B_WDATA(B_WDATA),
    .A_GNT(A_GNT), .A_RVALID(A_RVALID), .A_RDATA(A_RDATA), .A_ERR(A_ERR),
    .B_GNT(B_GNT), .B_RVALID(B_RVALID), .B_RDATA(B_RDATA), .B_ERR(B_ERR),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITE_READ(MEM_WRITE_READ),
    .MEM_WRITE_DATA(MEM_WRITE_DATA), .MEM_READ_DATA(MEM_READ_DATA)
  );

  // Memory model: combinational read, write on the rising edge.
  assign MEM_READ_DATA = mem[MEM_ADDRESS[7:0]];
  always @(posedge CLK) if (MEM_WRITE_READ) mem[MEM_ADDRESS[7:0]] <= MEM_WRITE_DATA;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_a(input logic req, input logic we, input logic lock,
                       input logic [WIDTH-1:0] addr, input logic [WIDTH-1:0] wdata);
    A_REQ = req; A_WE = we; A_LOCK = lock; A_ADDR = addr; A_WDATA = wdata;
  endtask

  task automatic set_b(input logic req, input logic we, input logic lock,
                       input logic [WIDTH-1:0] addr, input logic [WIDTH-1:0] wdata);
    B_REQ = req; B_WE = we; B_LOCK = lock; B_ADDR = addr; B_WDATA = wdata;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
    mem[5] = 32'hDEAD_BEEF;
    mem[1] = 32'h1111_1111;
    mem[2] = 32'h2222_2222;
    RESET = 1'b0;
    set_a(0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0);
    #2;
    check_eq("rst_a_gnt", A_GNT, 0);
    check_eq("rst_a_rvalid", A_RVALID, 0);
    check_eq("rst_a_rdata", A_RDATA, 0);
    check_eq("rst_b_rvalid", B_RVALID, 0);
    check_eq("rst_mem_we", MEM_WRITE_READ, 0);
    tick();
    tick();
    RESET = 1'b1;

    // 1: A read addr 5
    set_a(1, 0, 0, 5, 0);
    #1;
    check_eq("t1_a_gnt", A_GNT, 1);
    check_eq("t1_b_gnt", B_GNT, 0);
    check_eq("t1_mem_addr", MEM_ADDRESS, 5);
    check_eq("t1_mem_we", MEM_WRITE_READ, 0);
    tick();
    set_a(0, 0, 0, 0, 0);
    check_eq("t1_a_rvalid", A_RVALID, 1);
    check_eq("t1_a_rdata", A_RDATA, 32'hDEAD_BEEF);
    check_eq("t1_b_rvalid", B_RVALID, 0);
    check_eq("t1_b_rdata", B_RDATA, 0);
    check_eq("t1_b_err", B_ERR, 0);
    tick();
    check_eq("t1_a_rvalid_pulse", A_RVALID, 0);

    // 3: B write addr 10, A read it back, then B reads it
    set_b(1, 1, 0, 10, 32'h1234_5678);
    #1;
    check_eq("t3_b_gnt", B_GNT, 1);
    check_eq("t3_mem_we", MEM_WRITE_READ, 1);
    check_eq("t3_mem_wdata", MEM_WRITE_DATA, 32'h1234_5678);
    tick();
    set_b(0, 0, 0, 0, 0);
    check_eq("t3_b_rvalid_wr", B_RVALID, 0);
    set_a(1, 0, 0, 10, 0);
    #1;
    check_eq("t3_a_gnt", A_GNT, 1);
    tick();
    set_a(0, 0, 0, 0, 0);
    check_eq("t3_a_rvalid", A_RVALID, 1);
    check_eq("t3_a_rdata", A_RDATA, 32'h1234_5678);
    set_b(1, 0, 0, 10, 0);
    tick();
    set_b(0, 0, 0, 0, 0);
    check_eq("t3_b_rdata", B_RDATA, 32'h1234_5678);

    // 2: both request, no lock; last grant was B so A goes first
    set_a(1, 0, 0, 1, 0);
    set_b(1, 0, 0, 2, 0);
    for (int i = 0; i < 4; i++) begin
      logic exp_a;
      exp_a = (i % 2 == 0);
      #1;
      check_eq("t2_a_gnt", A_GNT, exp_a);
      check_eq("t2_b_gnt", B_GNT, !exp_a);
      tick();
      check_eq("t2_a_rvalid", A_RVALID, exp_a);
      check_eq("t2_b_rvalid", B_RVALID, !exp_a);
      check_eq("t2_rdata", exp_a ? A_RDATA : B_RDATA, exp_a ? 32'h1111_1111 : 32'h2222_2222);
    end
    set_a(0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0);
    tick();

    // 4: A locked burst with B pending
    set_a(1, 0, 1, 1, 0);
    set_b(1, 0, 0, 2, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("t4_burst_a_gnt", A_GNT, 1);
      check_eq("t4_burst_b_gnt", B_GNT, 0);
      tick();
    end
    #1;
    check_eq("t4_b_after_burst", B_GNT, 1);
    check_eq("t4_a_stalled", A_GNT, 0);
    tick();
    set_b(0, 0, 0, 0, 0);
    check_eq("t4_b_rvalid", B_RVALID, 1);
    check_eq("t4_b_rdata", B_RDATA, 32'h2222_2222);
    #1;
    check_eq("t4_a_again", A_GNT, 1);
    tick();
    set_a(0, 0, 0, 0, 0);
    tick();
    tick();

    // 5: out-of-range read and write
    set_a(1, 0, 0, 300, 0);
    #1;
    check_eq("t5_a_gnt", A_GNT, 1);
    check_eq("t5_mem_we_rd", MEM_WRITE_READ, 0);
    tick();
    check_eq("t5_rd_rvalid", A_RVALID, 1);
    check_eq("t5_rd_err", A_ERR, 1);
    check_eq("t5_rd_rdata", A_RDATA, 0);
    set_a(1, 1, 0, 300, 32'hCAFE_F00D);
    #1;
    check_eq("t5_mem_we_wr", MEM_WRITE_READ, 0);
    tick();
    set_a(0, 0, 0, 0, 0);
    check_eq("t5_wr_rvalid", A_RVALID, 1);
    check_eq("t5_wr_err", A_ERR, 1);
    check_eq("t5_mem_unchanged", mem[44], 32'hA000_002C);
    tick();
    check_eq("t5_err_pulse", A_ERR, 0);

    // 6: reset during beat 2 of a locked A burst
    set_a(1, 0, 1, 3, 0);
    tick();
    #1;
    check_eq("t6_beat2_gnt", A_GNT, 1);
    RESET = 1'b0;
    #1;
    check_eq("t6_rst_gnt", A_GNT, 0);
    check_eq("t6_rst_rvalid", A_RVALID, 0);
    check_eq("t6_rst_mem_addr", MEM_ADDRESS, 0);
    tick();
    set_a(0, 0, 0, 0, 0);
    RESET = 1'b1;
    tick();
    check_eq("t6_no_stale_rvalid", A_RVALID, 0);
    set_a(1, 0, 0, 1, 0);
    set_b(1, 0, 0, 2, 0);
    #1;
    check_eq("t6_tie_a", A_GNT, 1);
    check_eq("t6_tie_b", B_GNT, 0);
    tick();
    set_a(0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
